// File: rtl/graph_seq_sink.sv
// Capture stage for the reconvergent test design: registers q1/q2/q3, counts rising
// edges of q3 with a sticky wrap flag, and decodes the serial pattern 1011 on q1.
module graph_seq_sink (
    input  logic       clk,
    input  logic       rst,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] cnt,
    output logic       rise,
    output logic       wrap,
    output logic       match
);

    // Flop outputs
    logic       s1;
    logic       s2;
    logic       s3;
    logic       s3d;
    logic       live;
    logic       armed;
    logic [3:0] sreg;

    // Flop inputs
    logic       s1_d;
    logic       s2_d;
    logic       s3_d;
    logic       s3d_d;
    logic       live_d;
    logic       armed_d;
    logic [3:0] sreg_d;
    logic [3:0] cnt_d;
    logic       rise_d;
    logic       wrap_d;

    // Gate-level nets
    logic       rst_n;
    logic       clr;
    logic       clr_n;
    logic       s3d_n;
    logic       s3_n;
    logic       edge_raw;
    logic       re;
    logic       arm_set;
    logic       arm_or;
    logic [4:0] carry;
    logic [3:0] sum;
    logic       wrap_or;
    logic       sreg2_n;
    logic       dec_hi;
    logic       dec_lo;

    // Reset is folded into every D input, so it travels the same data paths
    // as the functional logic.
    assign rst_n = ~rst;
    assign clr   = rst | s2;
    assign clr_n = ~clr;

    assign s1_d  = rst_n & in1;
    assign s2_d  = rst_n & in2;
    assign s3_d  = rst_n & in3;
    assign s3d_d = rst_n & s3;

    // live marks that s3 holds a real post-reset sample; armed is set once that
    // sample was seen low, so in3 held high through reset release never pulses.
    assign live_d  = rst_n;
    assign s3_n    = ~s3;
    assign arm_set = live & s3_n;
    assign arm_or  = armed | arm_set;
    assign armed_d = rst_n & arm_or;

    assign s3d_n    = ~s3d;
    assign edge_raw = s3 & s3d_n;
    assign re       = edge_raw & armed;
    assign rise_d   = rst_n & re;

    // Ripple incrementer: the carry-in is the edge term, carry-out is the wrap event.
    assign carry[0] = re;
    assign sum[0]   = cnt[0] ^ carry[0];
    assign carry[1] = cnt[0] & carry[0];
    assign sum[1]   = cnt[1] ^ carry[1];
    assign carry[2] = cnt[1] & carry[1];
    assign sum[2]   = cnt[2] ^ carry[2];
    assign carry[3] = cnt[2] & carry[2];
    assign sum[3]   = cnt[3] ^ carry[3];
    assign carry[4] = cnt[3] & carry[3];

    // Clear gates the adder output, so it dominates a same-cycle increment.
    assign cnt_d[0] = clr_n & sum[0];
    assign cnt_d[1] = clr_n & sum[1];
    assign cnt_d[2] = clr_n & sum[2];
    assign cnt_d[3] = clr_n & sum[3];

    assign wrap_or = wrap | carry[4];
    assign wrap_d  = clr_n & wrap_or;

    assign sreg_d[0] = rst_n & s1;
    assign sreg_d[1] = rst_n & sreg[0];
    assign sreg_d[2] = rst_n & sreg[1];
    assign sreg_d[3] = rst_n & sreg[2];

    // Pattern decode is from sreg flops only; sreg[3] is the oldest bit.
    assign sreg2_n = ~sreg[2];
    assign dec_hi  = sreg[3] & sreg2_n;
    assign dec_lo  = sreg[1] & sreg[0];
    assign match   = dec_hi & dec_lo;

    always_ff @(posedge clk) begin
        s1    <= s1_d;
        s2    <= s2_d;
        s3    <= s3_d;
        s3d   <= s3d_d;
        live  <= live_d;
        armed <= armed_d;
        sreg  <= sreg_d;
        cnt   <= cnt_d;
        rise  <= rise_d;
        wrap  <= wrap_d;
    end

endmodule

// File: tb/tb_graph_seq_sink.sv
// Bench for graph_seq_sink: a behavioural model feeds an expected queue every
// cycle, plus directed checks of the counting, wrap, clear, pattern and reset cases.
module tb_graph_seq_sink;

    logic       clk;
    logic       rst;
    logic       in1;
    logic       in2;
    logic       in3;
    logic [3:0] cnt;
    logic       rise;
    logic       wrap;
    logic       match;

    int total;
    int bad;

    logic [6:0] exp_q[$];

    // Behavioural reference state
    logic       m_s1, m_s2, m_s3, m_s3d;
    logic       m_armed, m_low_seen;
    logic [3:0] m_sreg;
    logic [3:0] m_cnt;
    logic       m_rise, m_wrap;

    graph_seq_sink dut (
        .clk   (clk),
        .rst   (rst),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .cnt   (cnt),
        .rise  (rise),
        .wrap  (wrap),
        .match (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic i1, input logic i2, input logic i3);
        logic       m_re;
        logic [6:0] e;
        logic [6:0] got;
        rst = r;
        in1 = i1;
        in2 = i2;
        in3 = i3;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_s3 = 0; m_s3d = 0;
            m_armed = 0; m_low_seen = 0;
            m_sreg = 0; m_cnt = 0; m_rise = 0; m_wrap = 0;
        end else begin
            m_re   = m_s3 && !m_s3d && m_armed;
            m_rise = m_re;
            if (m_s2) begin
                m_cnt  = 4'd0;
                m_wrap = 1'b0;
            end else if (m_re) begin
                if (m_cnt == 4'd15) m_wrap = 1'b1;
                m_cnt = m_cnt + 4'd1;
            end
            m_sreg     = {m_sreg[2:0], m_s1};
            m_s3d      = m_s3;
            m_s1       = i1;
            m_s2       = i2;
            m_s3       = i3;
            m_armed    = m_low_seen;
            m_low_seen = m_low_seen | !i3;
        end
        e = {m_cnt, m_rise, m_wrap, (m_sreg == 4'b1011)};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {cnt, rise, wrap, match};
        if (exp_q.size() == 0) begin
            check("sb_empty", 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb", {1'b0, got}, {1'b0, e});
        end
    endtask

    // One counted event: in3 high for one sample, then low for one sample.
    task automatic pulse(input logic i1);
        step(0, i1, 0, 1);
        step(0, i1, 0, 0);
    endtask

    logic [8:0] pat_in;
    logic [8:0] pat_match;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1; in1 = 1; in2 = 1; in3 = 1;
        @(negedge clk);

        // Reset with all inputs high
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        check("rst_cnt", {4'd0, cnt}, 8'd0);
        check("rst_flags", {5'd0, rise, wrap, match}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            check("rel_rise", {7'd0, rise}, 8'd0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Counting 1..5
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 1);
            if (k > 1) check("cnt_rise_low", {7'd0, rise}, 8'd0);
            step(0, 0, 0, 0);
            check("cnt_rise_hi", {7'd0, rise}, 8'd1);
            check("cnt_val", {4'd0, cnt}, k[7:0]);
        end

        // Clear, then 16 events to wrap, then one more
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("clr_cnt", {4'd0, cnt}, 8'd0);
        for (int k = 1; k <= 16; k++) begin
            pulse($urandom_range(0, 1));
            if (k == 15) check("pre_wrap", {3'd0, cnt, wrap}, {3'd0, 4'd15, 1'b0});
        end
        check("wrap16", {3'd0, cnt, wrap}, {3'd0, 4'd0, 1'b1});
        pulse(0);
        check("wrap17", {3'd0, cnt, wrap}, {3'd0, 4'd1, 1'b1});

        // Clear against a same-cycle increment at cnt=7
        for (int k = 0; k < 6; k++) pulse(0);
        check("cnt7", {3'd0, cnt, wrap}, {3'd0, 4'd7, 1'b1});
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("clr_vs_inc", {3'd0, cnt, wrap}, 8'd0);
        step(0, 0, 0, 0);

        // Serial pattern with overlap
        pat_in    = 9'b001101101;
        pat_match = 9'b010010000;
        for (int i = 0; i < 9; i++) begin
            step(0, pat_in[i], 0, 0);
            check($sformatf("pat%0d", i), {7'd0, match}, {7'd0, pat_match[i]});
        end

        // Mid-operation reset with cnt=9, sreg=1011 and an edge pending
        step(0, 0, 1, 0);
        for (int k = 0; k < 9; k++) pulse(0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        check("pre_rst", {3'd0, cnt, match}, {3'd0, 4'd9, 1'b1});
        step(1, 0, 0, 1);
        check("mid_rst", {1'b0, cnt, rise, wrap, match}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            check("post_rst", {3'd0, cnt, rise}, 8'd0);
        end

        // Random tail, checked only against the model
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
